pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Multi-cycle control FSM that drives the CPU program counter and instruction fetch.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Generates the PC enable and next-PC select (00 increment, 01 immediate, 10 register/memory address), the IR load strobe, register-file write and memory write.
- Evaluates branch conditions from the PSR flags.
- Sits between unified instruction/data memory, the instruction register, the PSR and the program counter.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (1..7); FETCH and MEM each hold for MEM_LAT cycles.
- HALT_WORD, 16'hFFFF, instruction encoding that stops the sequencer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (sampled on posedge clk)
- run  in  1  level; permits starting a new instruction
- instr  in  16  memory read data; IR contents during DECODE/EXEC
- flags  in  5  PSR {C,L,F,Z,N}, [4]=C .. [0]=N
- pc_en  out  1  PC update strobe, one cycle per instruction
- pc_sel  out  2  00 increment, 01 imm, 10 mem_addr; only meaningful when pc_en=1
- ir_en  out  1  IR load strobe
- addr_sel  out  1  memory address source: 0=PC, 1=register (Rsrc)
- rf_we  out  1  register-file write enable
- mem_we  out  1  memory write enable
- state  out  3  current state encoding (debug)
- halted  out  1  high while in HALT

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, latency counter=0.
  - All strobes 0, pc_sel=00, addr_sel=0, halted=0.
  - Reset wins over every other condition, including mid-instruction and HALT.
- Outputs are Moore/registered-decode from state plus the IR; no output depends combinationally on run.
- IDLE: all strobes 0. run=1 -> FETCH next cycle.
- FETCH:
  - addr_sel=0; counter counts 0..MEM_LAT-1.
  - On the last count: ir_en=1 for that single cycle, then -> DECODE.
- DECODE: one cycle, no strobes.
  - instr==HALT_WORD -> HALT.
  - Otherwise classify:
    - opcode instr[15:12]=4'b0100 with ext instr[7:4]=0000 -> LOAD.
    - 0100/0100 -> STOR.
    - 0100/1100 -> JCOND.
    - 4'b1100 -> BCOND.
    - Any other encoding -> ALU.
  - Then -> EXEC.
- EXEC, one cycle:
  - ALU: rf_we=1, pc_en=1, pc_sel=00 -> FETCH.
  - STOR: addr_sel=1, mem_we=1, pc_en=1, pc_sel=00 -> FETCH.
  - BCOND: pc_en=1; pc_sel=01 if cond true else 00 -> FETCH.
  - JCOND: pc_en=1; pc_sel=10 if cond true else 00 -> FETCH.
  - LOAD: addr_sel=1, no strobes -> MEM.
- MEM: addr_sel=1, counts MEM_LAT cycles, then -> WB.
- WB: addr_sel=1, rf_we=1, pc_en=1, pc_sel=00 -> FETCH.
- Return to FETCH only if run=1; otherwise -> IDLE.
  - Deasserting run mid-instruction never aborts the instruction; it completes first.
- HALT: halted=1, all strobes 0, stays until rst.
- Condition field instr[11:8]:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 HI L; 0101 LS !L; 1010 LO !L&!Z; 1011 HS L|Z.
  - 0110 GT N; 0111 LE !N; 1100 LT !N&!Z; 1101 GE N|Z.
  - 1000 FS F; 1001 FC !F.
  - 1110 UC 1; 1111 never 0.
- Invariants:
  - Exactly one pc_en pulse per retired instruction.
  - ir_en and pc_en are never high in the same cycle.
  - mem_we only in STOR EXEC.

Optional Feature:
- Macro PC_SEQ_STALL_EN.
- Defined: adds input port stall (1 bit, after flags).
  - stall=1 freezes state and latency counter and forces pc_en, ir_en, rf_we and mem_we to 0 that cycle.
  - addr_sel and pc_sel hold their state-derived values.
  - rst overrides stall.
- Undefined: no stall port; behaviour as above.

Decomposition:
- Package pc_seq_pkg:
  - state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - pc_sel constants PC_INC=2'b00, PC_IMM=2'b01, PC_MEMADDR=2'b10.
  - opcode/ext constants for LOAD/STOR/JCOND/BCOND.
  - condition code constants.
- One natural sub-module: cond_eval (combinational, cond[3:0] + flags[4:0] -> taken).

Test Plan:
- Reset, run=1, MEM_LAT=1 -> FETCH at cycle 1, ir_en at cycle 1, DECODE 2, EXEC 3 with pc_en=1/pc_sel=00/rf_we=1 for ADD 16'h0512.
- BEQ 16'hC003 with Z=1 -> EXEC pc_sel=01. With Z=0 -> pc_sel=00. UC (cond 1110) is always taken; cond 1111 is never taken.
- LOAD 16'h4102, MEM_LAT=3 -> FETCH 3 cycles, MEM 3 cycles with addr_sel=1, WB rf_we=1+pc_en=1; total 9 cycles.
- STOR 16'h4143 -> mem_we=1 exactly one cycle with addr_sel=1. JCOND 16'h4EC3 -> pc_sel=10.
- run dropped during MEM -> LOAD completes WB, then IDLE. HALT_WORD -> halted=1 persists until rst=1, then IDLE.
- rst asserted in EXEC -> next cycle IDLE with all strobes 0. With PC_SEQ_STALL_EN, stall=1 for 4 cycles in FETCH -> no strobes, then resumes unchanged.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   - state_e   : FSM state encoding (also exported on the debug state port)
//   - iclass_e  : instruction class latched in DECODE and used in EXEC
//   - PC_*      : next-PC select encodings
//   - OPC_/EXT_ : opcode and extension fields that select LOAD/STOR/JCOND/BCOND
//   - CC_*      : branch condition codes held in instr[11:8]
//   - classify(): maps an IR word to its instruction class
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        IC_ALU   = 3'd0,
        IC_LOAD  = 3'd1,
        IC_STOR  = 3'd2,
        IC_BCOND = 3'd3,
        IC_JCOND = 3'd4
    } iclass_e;

    localparam logic [1:0] PC_INC     = 2'b00;
    localparam logic [1:0] PC_IMM     = 2'b01;
    localparam logic [1:0] PC_MEMADDR = 2'b10;

    localparam logic [3:0] OPC_MEM   = 4'b0100;
    localparam logic [3:0] OPC_BCOND = 4'b1100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    function automatic iclass_e classify(input logic [15:0] ir);
        iclass_e c;
        c = IC_ALU;
        if (ir[15:12] == OPC_MEM) begin
            case (ir[7:4])
                EXT_LOAD:  c = IC_LOAD;
                EXT_STOR:  c = IC_STOR;
                EXT_JCOND: c = IC_JCOND;
                default:   c = IC_ALU;
            endcase
        end else if (ir[15:12] == OPC_BCOND) begin
            c = IC_BCOND;
        end
        return c;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the sequencer's control/status signals.
//   run, instr, flags (and stall when PC_SEQ_STALL_EN is defined) flow into the
//   sequencer; pc_en, pc_sel, ir_en, addr_sel, rf_we, mem_we, state and halted
//   flow out. modport master = sequencer side, slave = datapath side.
// Build option: `define PC_SEQ_STALL_EN adds the stall input.
interface pc_sequencer_if;

    logic        run;
    logic [15:0] instr;
    logic [4:0]  flags;
`ifdef PC_SEQ_STALL_EN
    logic        stall;
`endif
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        ir_en;
    logic        addr_sel;
    logic        rf_we;
    logic        mem_we;
    logic [2:0]  state;
    logic        halted;

`ifdef PC_SEQ_STALL_EN
    modport master (
        input  run, instr, flags, stall,
        output pc_en, pc_sel, ir_en, addr_sel, rf_we, mem_we, state, halted
    );
    modport slave (
        output run, instr, flags, stall,
        input  pc_en, pc_sel, ir_en, addr_sel, rf_we, mem_we, state, halted
    );
`else
    modport master (
        input  run, instr, flags,
        output pc_en, pc_sel, ir_en, addr_sel, rf_we, mem_we, state, halted
    );
    modport slave (
        output run, instr, flags,
        input  pc_en, pc_sel, ir_en, addr_sel, rf_we, mem_we, state, halted
    );
`endif

endinterface

// File: rtl/pc_sequencer_cond_eval.sv
// cond_eval: combinational branch-condition evaluator.
//   cond_i  [3:0] condition field from instr[11:8]
//   flags_i [4:0] PSR {C,L,F,Z,N}
//   taken_o       1 when the condition holds
module cond_eval
    import pc_seq_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] flags_i,
    output logic       taken_o
);

    logic c_f, l_f, f_f, z_f, n_f;

    assign c_f = flags_i[4];
    assign l_f = flags_i[3];
    assign f_f = flags_i[2];
    assign z_f = flags_i[1];
    assign n_f = flags_i[0];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            CC_EQ:   taken_o = z_f;
            CC_NE:   taken_o = ~z_f;
            CC_CS:   taken_o = c_f;
            CC_CC:   taken_o = ~c_f;
            CC_HI:   taken_o = l_f;
            CC_LS:   taken_o = ~l_f;
            CC_LO:   taken_o = ~l_f & ~z_f;
            CC_HS:   taken_o = l_f | z_f;
            CC_GT:   taken_o = n_f;
            CC_LE:   taken_o = ~n_f;
            CC_LT:   taken_o = ~n_f & ~z_f;
            CC_GE:   taken_o = n_f | z_f;
            CC_FS:   taken_o = f_f;
            CC_FC:   taken_o = ~f_f;
            CC_UC:   taken_o = 1'b1;
            CC_NV:   taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM driving the
// program counter, IR load, register-file write and memory write.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : pc_sequencer_if.master (run/instr/flags in; strobes, state, halted out)
// Parameters: MEM_LAT (1..7) memory read latency, HALT_WORD stop encoding.
// Build option: `define PC_SEQ_STALL_EN adds bus.stall, which freezes the FSM and
// masks the four strobes for the cycle it is high.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read, MEM_LAT cycles, ir_en on the last
// DECODE | classify IR, latch branch condition
// EXEC   | one-cycle execute, strobes depend on class
// MEM    | load data read, MEM_LAT cycles
// WB     | load write-back and PC increment
// HALT   | halted until reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 1,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.master bus
);

    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    iclass_e    cls_q, cls_d;
    logic       taken_q, taken_d;
    logic       cond_taken;
    logic       stall;

    logic       pc_en_q,    pc_en_d;
    logic [1:0] pc_sel_q,   pc_sel_d;
    logic       ir_en_q,    ir_en_d;
    logic       addr_sel_q, addr_sel_d;
    logic       rf_we_q,    rf_we_d;
    logic       mem_we_q,   mem_we_d;
    logic       halted_q,   halted_d;

`ifdef PC_SEQ_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    cond_eval u_cond_eval (
        .cond_i  (bus.instr[11:8]),
        .flags_i (bus.flags),
        .taken_o (cond_taken)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        taken_d = taken_q;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (bus.run) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_DECODE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_DECODE: begin
                    cls_d   = classify(bus.instr);
                    taken_d = cond_taken;
                    state_d = (bus.instr == HALT_WORD) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    cnt_d = '0;
                    if (cls_q == IC_LOAD) state_d = ST_MEM;
                    else                  state_d = bus.run ? ST_FETCH : ST_IDLE;
                end
                ST_MEM: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_WB;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_WB: begin
                    cnt_d   = '0;
                    state_d = bus.run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they register together
    // with it and line up with the state they belong to.
    always_comb begin
        pc_en_d    = 1'b0;
        pc_sel_d   = PC_INC;
        ir_en_d    = 1'b0;
        addr_sel_d = 1'b0;
        rf_we_d    = 1'b0;
        mem_we_d   = 1'b0;
        halted_d   = 1'b0;
        case (state_d)
            ST_FETCH: ir_en_d = (cnt_d == LAST_CNT);
            ST_EXEC: begin
                case (cls_d)
                    IC_ALU: begin
                        rf_we_d = 1'b1;
                        pc_en_d = 1'b1;
                    end
                    IC_STOR: begin
                        addr_sel_d = 1'b1;
                        mem_we_d   = 1'b1;
                        pc_en_d    = 1'b1;
                    end
                    IC_BCOND: begin
                        pc_en_d  = 1'b1;
                        pc_sel_d = taken_d ? PC_IMM : PC_INC;
                    end
                    IC_JCOND: begin
                        pc_en_d  = 1'b1;
                        pc_sel_d = taken_d ? PC_MEMADDR : PC_INC;
                    end
                    IC_LOAD: addr_sel_d = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: addr_sel_d = 1'b1;
            ST_WB: begin
                addr_sel_d = 1'b1;
                rf_we_d    = 1'b1;
                pc_en_d    = 1'b1;
            end
            ST_HALT: halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cls_q      <= IC_ALU;
            taken_q    <= 1'b0;
            pc_en_q    <= 1'b0;
            pc_sel_q   <= PC_INC;
            ir_en_q    <= 1'b0;
            addr_sel_q <= 1'b0;
            rf_we_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cls_q      <= cls_d;
            taken_q    <= taken_d;
            pc_en_q    <= pc_en_d;
            pc_sel_q   <= pc_sel_d;
            ir_en_q    <= ir_en_d;
            addr_sel_q <= addr_sel_d;
            rf_we_q    <= rf_we_d;
            mem_we_q   <= mem_we_d;
            halted_q   <= halted_d;
        end
    end

    // A stalled cycle keeps its registered strobes for when the stall lifts,
    // but must not let them act while frozen.
    assign bus.pc_en    = pc_en_q  & ~stall;
    assign bus.ir_en    = ir_en_q  & ~stall;
    assign bus.rf_we    = rf_we_q  & ~stall;
    assign bus.mem_we   = mem_we_q & ~stall;
    assign bus.pc_sel   = pc_sel_q;
    assign bus.addr_sel = addr_sel_q;
    assign bus.state    = state_q;
    assign bus.halted   = halted_q;

endmodule
